// File: rtl/bin2bcd_16.sv
// bin2bcd_16: sequential shift-and-add-3 binary to packed BCD converter.
// Ports: clock, reset (async, active-low), start, bin -> bcd, busy, done.
module bin2bcd_16 #(
  parameter int BIT_SZ = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIT_SZ-1:0]     bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(BIT_SZ + 1);
  localparam int BW = 4 * DIGITS;
  localparam logic [CW-1:0] LAST = CW'(BIT_SZ - 1);

  typedef enum logic {
    IDLE,
    CONV
  } state_t;

  state_t            state;
  logic [BIT_SZ-1:0] shreg;
  logic [BW-1:0]     scratch;
  logic [CW-1:0]     cnt;

  logic [BW-1:0]     adj;
  logic [BW-1:0]     scr_nxt;
  logic [BIT_SZ-1:0] sh_nxt;

  // Nibbles >= 5 get +3 so the following
  // doubling carries into the next digit.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  // {scratch, shreg} shifted left by one.
  always_comb begin
    scr_nxt = (adj << 1)
            | {{(BW-1){1'b0}}, shreg[BIT_SZ-1]};
    sh_nxt  = shreg << 1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      shreg   <= '0;
      scratch <= '0;
      cnt     <= '0;
      bcd     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            shreg   <= bin;
            scratch <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= CONV;
          end
        end
        CONV: begin
          shreg   <= sh_nxt;
          scratch <= scr_nxt;
          cnt     <= cnt + CW'(1);
          if (cnt == LAST) begin
            bcd   <= scr_nxt;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
